tx_frame_scheduler: RTL and testbench

Byte-level frame scheduler in front of the TX bit path. It shares the single TX stream between two byte requesters using round-robin arbitration. Each granted packet is wrapped as: preamble bytes, a 16-bit sync word, the payload, then an idle inter-frame gap. Its output feeds the 8->1 stream_resizer ahead of TX_path_top.

---
 rtl/tx_frame_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_scheduler
// Purpose  : Round-robin byte-frame scheduler for two requesters. Each frame is
//            sent as preamble, sync word, payload, then an idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module tx_frame_scheduler #(
   parameter int          PREAMBLE_LEN  = 4,
   parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
   parameter logic [15:0] SYNC_WORD     = 16'hD391,
   parameter int          MAX_PAYLOAD   = 64,
   parameter int          GAP_CYCLES    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  in_valid,
   input  logic [15:0] in_data,
   input  logic [1:0]  in_last,
   output logic [1:0]  in_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        frame_done,
   output logic        err_trunc
);

   localparam int c_PRE_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
   localparam int c_PAY_W = $clog2(MAX_PAYLOAD + 1);
   localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_PREAMBLE = 3'd1;
   localparam logic [2:0] c_SYNC     = 3'd2;
   localparam logic [2:0] c_PAYLOAD  = 3'd3;
   localparam logic [2:0] c_DRAIN    = 3'd4;
   localparam logic [2:0] c_GAP      = 3'd5;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [c_PRE_W-1:0] r_pre_cnt;
   logic               r_sync_lo;
   logic [c_PAY_W-1:0] r_pay_cnt;
   logic [c_GAP_W-1:0] r_gap_cnt;
   logic               r_last_served;
   logic               r_gidx;
   logic [1:0]         r_grant;
   logic               r_out_valid;
   logic [7:0]         r_out_data;

   logic               w_load_en;
   logic               w_load;
   logic [7:0]         w_load_data;
   logic               w_pick;
   logic               w_sel_valid;
   logic               w_sel_last;
   logic [7:0]         w_sel_data;
   logic               w_xfer;
   logic               w_pre_end;
   logic               w_pay_full;
   logic               w_gap_done;

   assign w_load_en   = !r_out_valid || out_ready;
   assign w_pick      = in_valid[~r_last_served] ? ~r_last_served : r_last_served;
   assign w_sel_valid = r_gidx ? in_valid[1] : in_valid[0];
   assign w_sel_last  = r_gidx ? in_last[1]  : in_last[0];
   assign w_sel_data  = r_gidx ? in_data[15:8] : in_data[7:0];
   assign w_xfer      = (r_state == c_PAYLOAD) && w_sel_valid && w_load_en;
   assign w_pre_end   = (r_pre_cnt == c_PRE_W'(PREAMBLE_LEN - 1));
   assign w_pay_full  = (r_pay_cnt == c_PAY_W'(MAX_PAYLOAD - 1));
   // The gap only starts counting once the last byte has left the output register.
   assign w_gap_done  = (r_state == c_GAP) && !r_out_valid &&
                        (r_gap_cnt == c_GAP_W'(GAP_CYCLES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:     if (|in_valid) w_state_nxt = c_PREAMBLE;
         c_PREAMBLE: if (w_load_en && w_pre_end) w_state_nxt = c_SYNC;
         c_SYNC:     if (w_load_en && r_sync_lo) w_state_nxt = c_PAYLOAD;
         c_PAYLOAD: begin
            if (w_xfer) begin
               if (w_sel_last)      w_state_nxt = c_GAP;
               else if (w_pay_full) w_state_nxt = c_DRAIN;
            end
         end
         c_DRAIN:    if (w_sel_valid && w_sel_last) w_state_nxt = c_GAP;
         c_GAP:      if (w_gap_done) w_state_nxt = c_IDLE;
         default:    w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_load      = 1'b0;
      w_load_data = 8'h00;
      in_ready    = 2'b00;
      err_trunc   = 1'b0;
      frame_done  = 1'b0;
      case (r_state)
         c_PREAMBLE: begin
            w_load      = w_load_en;
            w_load_data = PREAMBLE_BYTE;
         end
         c_SYNC: begin
            w_load      = w_load_en;
            w_load_data = r_sync_lo ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
         end
         c_PAYLOAD: begin
            in_ready    = w_load_en ? r_grant : 2'b00;
            w_load      = w_xfer;
            w_load_data = w_sel_data;
            err_trunc   = w_xfer && !w_sel_last && w_pay_full;
         end
         c_DRAIN:    in_ready   = r_grant;
         c_GAP:      frame_done = w_gap_done;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_load_data;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pre_cnt     <= '0;
         r_sync_lo     <= 1'b0;
         r_pay_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_last_served <= 1'b1;
         r_gidx        <= 1'b0;
         r_grant       <= 2'b00;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_pre_cnt <= '0;
               r_sync_lo <= 1'b0;
               r_pay_cnt <= '0;
               r_gap_cnt <= '0;
               if (|in_valid) begin
                  r_gidx        <= w_pick;
                  r_last_served <= w_pick;
                  r_grant       <= w_pick ? 2'b10 : 2'b01;
               end
            end
            c_PREAMBLE: begin
               if (w_load_en) r_pre_cnt <= w_pre_end ? '0 : r_pre_cnt + 1'b1;
            end
            c_SYNC: begin
               if (w_load_en) r_sync_lo <= !r_sync_lo;
            end
            c_PAYLOAD: begin
               if (w_xfer) r_pay_cnt <= r_pay_cnt + 1'b1;
            end
            c_GAP: begin
               if (w_gap_done)        r_grant   <= 2'b00;
               else if (!r_out_valid) r_gap_cnt <= r_gap_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign grant     = r_grant;
   assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_frame_scheduler
// Purpose  : Randomized self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frame_scheduler;

   localparam int c_PRE_LEN = 4;
   localparam int c_MAX     = 64;
   localparam int c_GAP     = 8;

   logic        clk;
   logic        rst;
   logic [1:0]  in_valid, in_last, in_ready, grant;
   logic [15:0] in_data;
   logic        out_valid, out_ready, busy, frame_done, err_trunc;
   logic [7:0]  out_data;

   logic [1:0]  e_in_valid, e_in_last, e_in_ready, e_grant;
   logic [15:0] e_in_data;
   logic        e_out_valid, e_out_ready, e_busy, e_frame_done, e_err_trunc;
   logic [7:0]  e_out_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   tx_frame_scheduler dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .grant(grant), .busy(busy), .frame_done(frame_done), .err_trunc(err_trunc)
   );

   tx_frame_scheduler #(.PREAMBLE_LEN(1), .GAP_CYCLES(0)) dut_edge (
      .clk(clk), .rst(rst),
      .in_valid(e_in_valid), .in_data(e_in_data), .in_last(e_in_last), .in_ready(e_in_ready),
      .out_valid(e_out_valid), .out_data(e_out_data), .out_ready(e_out_ready),
      .grant(e_grant), .busy(e_busy), .frame_done(e_frame_done), .err_trunc(e_err_trunc)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Reference model: pending bytes per requester and the expected output stream
   // as (owner << 8) | byte, in frame order.
   logic [7:0] pk_data[2][$];
   bit         pk_last[2][$];
   int         pk_idx[2];
   int         stall[2];
   int         exp_q[$];
   int         m_ls = 1;
   int         exp_frames = 0, got_frames = 0, exp_trunc = 0, got_trunc = 0;
   int         cyc = 0, last_acc_cyc = 0, last_end_cyc = 0;
   bit         bp = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   task automatic plan(input int n0, input int n1, input int minlen, input int maxlen, input int base);
      int left[2];
      int p, len;
      logic [7:0] b;
      left[0] = n0;
      left[1] = n1;
      while (left[0] + left[1] > 0) begin
         p = (left[1 - m_ls] > 0) ? 1 - m_ls : m_ls;
         m_ls = p;
         left[p]--;
         exp_frames++;
         len = $urandom_range(maxlen, minlen);
         for (int i = 0; i < c_PRE_LEN; i++) exp_q.push_back((p << 8) | 'h55);
         exp_q.push_back((p << 8) | 'hD3);
         exp_q.push_back((p << 8) | 'h91);
         for (int i = 0; i < len; i++) begin
            b = (base < 0) ? 8'($urandom) : 8'(base + i);
            pk_data[p].push_back(b);
            pk_last[p].push_back(i == len - 1);
            if (i < c_MAX) exp_q.push_back((p << 8) | int'(b));
         end
         if (len > c_MAX) exp_trunc++;
      end
   endtask

   task automatic drive();
      for (int n = 0; n < 2; n++) begin
         if (stall[n] > 0) begin
            stall[n]--;
            in_valid[n] = 1'b0;
            in_data[8*n +: 8] = 8'($urandom);
            in_last[n] = 1'($urandom);
         end else if (pk_data[n].size() > 0) begin
            in_valid[n] = 1'b1;
            in_data[8*n +: 8] = pk_data[n][0];
            in_last[n] = pk_last[n][0];
         end else begin
            in_valid[n] = 1'b0;
            in_data[8*n +: 8] = 8'($urandom);
            in_last[n] = 1'($urandom);
         end
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic step();
      int e, t0;
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("extra_out_byte", {24'd0, out_data}, 32'h100);
         else begin
            e = exp_q.pop_front();
            check("out_data", {24'd0, out_data}, e & 255);
            check("out_grant", {30'd0, grant}, 1 << (e >> 8));
         end
         last_acc_cyc = cyc;
      end
      if (prev_stall) begin
         check("hold_valid", {31'd0, out_valid}, 1);
         check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      check("grant_onehot0", {31'd0, $onehot0(grant)}, 1);
      check("ready_owner", {30'd0, in_ready & ~grant}, 0);
      for (int n = 0; n < 2; n++)
         if (out_valid && !out_ready && pk_idx[n] < c_MAX)
            check("ready_stall", {31'd0, in_ready[n]}, 0);
      if (err_trunc) got_trunc++;
      if (frame_done) begin
         got_frames++;
         t0 = (last_acc_cyc > last_end_cyc) ? last_acc_cyc : last_end_cyc;
         check("gap_len", cyc - t0, c_GAP + 1);
      end
      for (int n = 0; n < 2; n++) begin
         if (in_valid[n] && in_ready[n]) begin
            if (pk_last[n][0]) begin
               pk_idx[n] = 0;
               last_end_cyc = cyc;
            end else begin
               pk_idx[n]++;
               if (bp && $urandom_range(0, 3) == 0) stall[n] = $urandom_range(1, 3);
            end
            void'(pk_data[n].pop_front());
            void'(pk_last[n].pop_front());
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run(input bit mode, input int budget);
      int t;
      bp = mode;
      t = 0;
      while (got_frames < exp_frames && t < budget) begin
         step();
         t++;
      end
      check("frames_in_time", got_frames, exp_frames);
      bp = 1'b0;
      step();
      check("trunc_count", got_trunc, exp_trunc);
      check("exp_drained", exp_q.size(), 0);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_grant", {30'd0, grant}, 0);
   endtask

   task automatic edge_test();
      logic [7:0] d[2][$];
      int eq[$];
      int p, e, t, frames, prev_done;
      logic [7:0] b;
      frames = 0;
      prev_done = -1;
      for (int f = 0; f < 8; f++) begin
         p = f % 2;
         b = 8'($urandom);
         d[p].push_back(b);
         eq.push_back((p << 8) | 'h55);
         eq.push_back((p << 8) | 'hD3);
         eq.push_back((p << 8) | 'h91);
         eq.push_back((p << 8) | int'(b));
      end
      t = 0;
      while (frames < 8 && t < 400) begin
         for (int n = 0; n < 2; n++) begin
            e_in_valid[n] = (d[n].size() > 0);
            e_in_data[8*n +: 8] = (d[n].size() > 0) ? d[n][0] : 8'h00;
            e_in_last[n] = 1'b1;
         end
         @(negedge clk);
         t++;
         if (e_out_valid) begin
            if (eq.size() == 0) check("edge_extra_byte", 1, 0);
            else begin
               e = eq.pop_front();
               check("edge_out_data", {24'd0, e_out_data}, e & 255);
               check("edge_grant", {30'd0, e_grant}, 1 << (e >> 8));
            end
         end
         if (e_frame_done) begin
            frames++;
            if (prev_done >= 0) check("edge_period", t - prev_done, 7);
            prev_done = t;
         end
         for (int n = 0; n < 2; n++)
            if (e_in_valid[n] && e_in_ready[n]) void'(d[n].pop_front());
         @(posedge clk);
         #1;
      end
      check("edge_frames", frames, 8);
      check("edge_exp_left", eq.size(), 0);
      check("edge_busy", {31'd0, e_busy}, 0);
      check("edge_trunc", {31'd0, e_err_trunc}, 0);
   endtask

   initial begin
      rst = 1'b0;
      in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
      e_in_valid = '0; e_in_data = '0; e_in_last = '0; e_out_ready = 1'b1;
      pk_idx[0] = 0; pk_idx[1] = 0; stall[0] = 0; stall[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", {24'd0, out_data}, 0);
      check("rst_grant", {30'd0, grant}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_in_ready", {30'd0, in_ready}, 0);
      check("rst_pulses", {30'd0, frame_done, err_trunc}, 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      plan(1, 0, 3, 3, 'hA1);      run(1'b0, 200);
      plan(3, 3, 2, 2, -1);        run(1'b0, 1000);
      plan(4, 3, 1, 20, -1);       run(1'b1, 4000);
      plan(0, 1, 70, 70, -1);      run(1'b1, 2000);
      plan(1, 0, 64, 64, -1);      run(1'b1, 2000);
      plan(0, 1, 65, 65, -1);      run(1'b0, 2000);
      plan(1, 0, 2, 2, -1);        run(1'b0, 300);

      // Last frame went to requester 0, so requester 1 wins this one until reset hits.
      plan(1, 1, 5, 5, -1);
      repeat (4) step();
      rst = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 0);
      check("abort_out_data", {24'd0, out_data}, 0);
      check("abort_grant", {30'd0, grant}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      for (int n = 0; n < 2; n++) begin
         pk_data[n].delete();
         pk_last[n].delete();
         pk_idx[n] = 0;
         stall[n] = 0;
      end
      exp_q.delete();
      exp_frames = got_frames;
      m_ls = 1;
      prev_stall = 1'b0;
      in_valid = '0;
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      plan(1, 1, 4, 4, -1);        run(1'b0, 300);

      edge_test();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
